online_otf_converter: RTL and testbench
=======================================

# online_otf_converter

Downstream consumer of the quotient-digit selection stage in the online divider. Accepts one signed quotient digit per handshake (encoding 2'b10 = +1, 2'b01 = −1, 2'b00 = 0) and converts the redundant digit stream into a conventional two's-complement quotient on the fly. It keeps the Q / QM register pair, so no carry-propagate addition is needed at the end. After N digits it presents the quotient with a valid/ready handshake.

## Interface
- `N`, default 16: number of quotient digits per division; must be ≥ 2.
- `W`, derived as N+1: result width (sign bit plus N fraction bits).
- `clk`, input, 1: single clock; all state updates on rising edge.
- `rst_n`, input, 1: reset. Synchronous and active-low.
- `start`, input, 1: begin a new conversion. Honoured only in IDLE.
- `q_valid`, input, 1: `q_digit` is valid this cycle.
- `q_digit`, input, 2: signed digit from the selection stage.
- `q_ready`, output, 1: converter accepts a digit this cycle.
- `quotient`, output, W: two's-complement result, value = quotient·2^−N.
- `result_valid`, output, 1: `quotient` is final.
- `result_ready`, input, 1: consumer takes the result.
- `busy`, output, 1: state is not IDLE.
- `err_digit`, output, 1: sticky flag; an illegal digit 2'b11 was accepted during the current conversion.

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
- **IDLE**
  - `start`=1: Q ← 0, QM ← all-ones (−1), cnt ← 0, `err_digit` ← 0, then RUN.
  - `q_valid` is ignored.
- **RUN**
  - `q_ready`=1.
  - On `q_valid`: accept `q_digit` and update, with `{X,b}` = (X<<1)|b truncated to W bits:
    - +1: Q ← {Q,1}, QM ← {Q,0}
    - 0: Q ← {Q,0}, QM ← {QM,1}
    - −1: Q ← {QM,1}, QM ← {QM,0}
    - 2'b11: treated as 0; `err_digit` ← 1.
  - cnt ← cnt+1 on every accepted digit.
  - Acceptance with cnt = N−1 moves the FSM to DONE.
  - `start` is ignored.
- **DONE**
  - `result_valid`=1; `quotient` = Q, held stable.
  - On `result_ready`: go to IDLE.
  - `q_valid` and `start` are ignored.
- Invariant after every accepted digit: QM = Q − 1 (mod 2^W).
- Counter width is $clog2(N+1); cnt never exceeds N−1 in RUN.
- `quotient` always drives Q, but is meaningful only while `result_valid`=1.

## Timing
- Reset values (`rst_n`=0 at a rising edge):
  - state = IDLE, Q = 0, QM = all-ones, cnt = 0.
  - `q_ready` = 0, `result_valid` = 0, `busy` = 0, `err_digit` = 0.
- Reset mid-RUN or mid-DONE aborts the conversion with no result. Reset has priority over all inputs.
- Latency:
  - RUN is entered the cycle after `start`.
  - The N-th digit is accepted at edge k; `result_valid` is high from edge k onward.
- Throughput: one digit per cycle when `q_valid` is held high. The minimum conversion is 1 + N + 1 cycles (start, N digits, result handshake).
- `q_ready` is a pure state decode, with no combinational path from `q_valid`.
- In IDLE after a handshake, a new `start` is accepted on the next edge.
- `start` and `result_ready` in the same DONE cycle: the FSM returns to IDLE and `start` is dropped.
- Gaps in `q_valid` during RUN stall the converter without limit; registers hold.

## Structure
- Shared divider package holds:
  - digit encoding constants `QD_POS` = 2'b10, `QD_NEG` = 2'b01, `QD_ZERO` = 2'b00, shared with the selection stage;
  - the FSM state enum (IDLE, RUN, DONE).
- One natural sub-module, `otf_qqm_update`: combinational next-Q / next-QM from (Q, QM, digit). The FSM and counter stay in the top module.

## Test plan
All scenarios use N=4, W=5.
- Digits +1, 0, −1, +1 back-to-back → `quotient` = 5'b00111 (7/16); `result_valid` rises 4 edges after the first digit; `err_digit` = 0.
- Digits −1, −1, −1, −1 → 5'b10001 (−15/16). Digits 0, 0, 0, 0 → 5'b00000.
- Digits −1, +1, +1, +1 with `q_valid` low for 2 cycles between digits 2 and 3 → 5'b11111 (−1/16); `q_ready` stays high through the gaps and Q / QM hold.
- Digit 2'b11 in position 2, others +1 → `err_digit` = 1, result equals 0 in that slot (5'b01011); the next `start` clears `err_digit`.
- `rst_n` low after the 2nd digit → all outputs at reset values the next cycle; a new `start` followed by 4 digits gives the correct fresh result.
- DONE held with `result_ready` = 0 for 5 cycles while `q_valid` and `start` toggle → `quotient` is stable and no state change occurs; `result_ready` = 1 → IDLE, `busy` = 0 next cycle.

Source files
------------

// File: rtl/online_otf_converter_pkg.sv
// Shared divider definitions: signed quotient-digit encoding and converter FSM states.
// The digit constants are common to the selection stage and the on-the-fly converter.
package online_otf_converter_pkg;

    typedef logic [1:0] qd_t;

    localparam qd_t QD_POS  = 2'b10;
    localparam qd_t QD_NEG  = 2'b01;
    localparam qd_t QD_ZERO = 2'b00;
    localparam qd_t QD_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic digit_illegal(input qd_t d);
        return d == QD_ILL;
    endfunction

endpackage

// File: rtl/online_otf_converter_if.sv
// Digit-in / result-out channels of the converter; master = digit source and result consumer.
interface online_otf_converter_if #(
    parameter int W = 17
);
    logic         q_valid;
    logic [1:0]   q_digit;
    logic         q_ready;
    logic [W-1:0] quotient;
    logic         result_valid;
    logic         result_ready;

    modport master (
        output q_valid, q_digit, result_ready,
        input  q_ready, quotient, result_valid
    );

    modport slave (
        input  q_valid, q_digit, result_ready,
        output q_ready, quotient, result_valid
    );
endinterface

// File: rtl/online_otf_converter_qqm_update.sv
// Purpose: next Q / QM of the on-the-fly conversion register pair for one signed digit.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is committed.
module otf_qqm_update
    import online_otf_converter_pkg::*;
#(
    parameter int W = 17
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] qm,
    input  qd_t          digit,
    output logic [W-1:0] q_nxt,
    output logic [W-1:0] qm_nxt,
    output logic         illegal
);

    // Appending a digit never needs a carry: Q or QM already holds the borrowed prefix.
    always_comb begin
        q_nxt  = {q[W-2:0], 1'b0};
        qm_nxt = {qm[W-2:0], 1'b1};
        unique case (digit)
            QD_POS: begin
                q_nxt  = {q[W-2:0], 1'b1};
                qm_nxt = {q[W-2:0], 1'b0};
            end
            QD_NEG: begin
                q_nxt  = {qm[W-2:0], 1'b1};
                qm_nxt = {qm[W-2:0], 1'b0};
            end
            default: begin
                q_nxt  = {q[W-2:0], 1'b0};
                qm_nxt = {qm[W-2:0], 1'b1};
            end
        endcase
    end

    assign illegal = digit_illegal(digit);

endmodule

// File: rtl/online_otf_converter.sv
// Purpose: converts a stream of N signed quotient digits into a two's-complement quotient.
// Latency: result_valid at the edge accepting the N-th digit; one digit per cycle max.
// Backpressure: q_ready is a state decode; DONE holds the result until result_ready.
module online_otf_converter
    import online_otf_converter_pkg::*;
#(
    parameter int N = 16,
    localparam int W = N + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       err_digit,
    online_otf_converter_if.slave      bus
);

    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  q_reg;
    logic [W-1:0]  qm_reg;
    logic          err_reg;

    logic [W-1:0]  q_nxt;
    logic [W-1:0]  qm_nxt;
    logic          digit_bad;
    logic          digit_take;

    otf_qqm_update #(.W(W)) u_update (
        .q       (q_reg),
        .qm      (qm_reg),
        .digit   (bus.q_digit),
        .q_nxt   (q_nxt),
        .qm_nxt  (qm_nxt),
        .illegal (digit_bad)
    );

    assign digit_take = (state == S_RUN) && bus.q_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            q_reg   <= '0;
            qm_reg  <= '1;
            err_reg <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        q_reg   <= '0;
                        qm_reg  <= '1;
                        cnt     <= '0;
                        err_reg <= 1'b0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (digit_take) begin
                        q_reg  <= q_nxt;
                        qm_reg <= qm_nxt;
                        cnt    <= cnt + CW'(1);
                        if (digit_bad) begin
                            err_reg <= 1'b1;
                        end
                        if (cnt == CW'(N - 1)) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // A start coinciding with the handshake is dropped on purpose.
                    if (bus.result_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.q_ready      = (state == S_RUN);
    assign bus.result_valid = (state == S_DONE);
    assign bus.quotient     = q_reg;
    assign busy             = (state != S_IDLE);
    assign err_digit        = err_reg;

endmodule

// File: tb/tb_online_otf_converter.sv
// Directed bench for online_otf_converter with N=4; expected quotients come from a digit-sum model.
module tb_online_otf_converter;
    import online_otf_converter_pkg::*;

    localparam int N = 4;
    localparam int W = N + 1;

    typedef struct packed {
        logic [W-1:0] q;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic err_digit;

    online_otf_converter_if #(.W(W)) bus ();

    online_otf_converter #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .err_digit (err_digit),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    logic [1:0]  dseq [4];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int dval(input logic [1:0] d);
        if (d == 2'b10) return 1;
        if (d == 2'b01) return -1;
        return 0;
    endfunction

    // Value of the first k digits as a signed integer, truncated to W bits.
    function automatic logic [W-1:0] model(input int k);
        int v;
        v = 0;
        for (int i = 0; i < k; i++) v = v * 2 + dval(dseq[i]);
        return W'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] d);
        bus.q_valid = 1'b1;
        bus.q_digit = d;
        tick();
        bus.q_valid = 1'b0;
        bus.q_digit = 2'b00;
    endtask

    task automatic collect(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.result_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_rv"}, 32'(bus.result_valid), 32'd1);
        e = sb.pop_front();
        check({tag, "_quot"}, 32'(bus.quotient), 32'(e.q));
        check({tag, "_err"}, 32'(err_digit), 32'(e.err));
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Full back-to-back conversion of dseq; want is the hand-derived quotient.
    task automatic conv(input string tag, input logic [W-1:0] want, input logic want_err);
        sb.push_back('{q: model(4), err: want_err});
        do_start();
        check({tag, "_rdy"}, 32'(bus.q_ready), 32'd1);
        for (int i = 0; i < 3; i++) send(dseq[i]);
        check({tag, "_rv_early"}, 32'(bus.result_valid), 32'd0);
        send(dseq[3]);
        check({tag, "_rv_lat"}, 32'(bus.result_valid), 32'd1);
        check({tag, "_const"}, 32'(bus.quotient), 32'(want));
        collect(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] held;
        bus.q_valid      = 1'b0;
        bus.q_digit      = 2'b00;
        bus.result_ready = 1'b0;

        tick();
        tick();
        check("rst_rdy", 32'(bus.q_ready), 32'd0);
        check("rst_rv", 32'(bus.result_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_digit), 32'd0);
        check("rst_quot", 32'(bus.quotient), 32'd0);
        rst_n = 1'b1;

        // IDLE ignores digits
        send(QD_POS);
        send(QD_POS);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_quot", 32'(bus.quotient), 32'd0);

        dseq = '{QD_POS, QD_ZERO, QD_NEG, QD_POS};
        conv("mix", 5'b00111, 1'b0);

        dseq = '{QD_NEG, QD_NEG, QD_NEG, QD_NEG};
        conv("neg", 5'b10001, 1'b0);

        dseq = '{QD_ZERO, QD_ZERO, QD_ZERO, QD_ZERO};
        conv("zero", 5'b00000, 1'b0);

        // Stall two cycles between digits 2 and 3
        dseq = '{QD_NEG, QD_POS, QD_POS, QD_POS};
        sb.push_back('{q: model(4), err: 1'b0});
        do_start();
        send(dseq[0]);
        send(dseq[1]);
        held = model(2);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("gap_rdy", 32'(bus.q_ready), 32'd1);
            check("gap_hold", 32'(bus.quotient), 32'(held));
        end
        send(dseq[2]);
        send(dseq[3]);
        check("gap_const", 32'(bus.quotient), 32'h1f);
        collect("gap");

        dseq = '{QD_POS, QD_ILL, QD_POS, QD_POS};
        conv("ill", 5'b01011, 1'b1);
        do_start();
        check("ill_clear", 32'(err_digit), 32'd0);
        for (int i = 0; i < 4; i++) send(QD_ZERO);
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;

        // Reset after the 2nd digit aborts the conversion
        do_start();
        send(QD_POS);
        send(QD_ILL);
        check("abort_err_set", 32'(err_digit), 32'd1);
        rst_n = 1'b0;
        tick();
        check("abort_rdy", 32'(bus.q_ready), 32'd0);
        check("abort_rv", 32'(bus.result_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_err", 32'(err_digit), 32'd0);
        check("abort_quot", 32'(bus.quotient), 32'd0);
        rst_n = 1'b1;
        dseq = '{QD_POS, QD_NEG, QD_NEG, QD_POS};
        conv("fresh", 5'b00011, 1'b0);

        // DONE holds while inputs toggle; start with result_ready is dropped
        dseq = '{QD_NEG, QD_ZERO, QD_POS, QD_ZERO};
        sb.push_back('{q: model(4), err: 1'b0});
        do_start();
        for (int i = 0; i < 4; i++) send(dseq[i]);
        for (int i = 0; i < 5; i++) begin
            bus.q_valid = i[0];
            start       = ~i[0];
            bus.q_digit = (i[0]) ? QD_POS : QD_ILL;
            tick();
            check("hold_rv", 32'(bus.result_valid), 32'd1);
            check("hold_quot", 32'(bus.quotient), 32'h1a);
        end
        bus.q_valid = 1'b0;
        start       = 1'b0;
        check("hold_err", 32'(err_digit), 32'd0);
        check("hold_model", 32'(bus.quotient), 32'(sb[0].q));
        void'(sb.pop_front());
        start            = 1'b1;
        bus.result_ready = 1'b1;
        tick();
        start            = 1'b0;
        bus.result_ready = 1'b0;
        check("drop_busy", 32'(busy), 32'd0);
        tick();
        check("drop_busy2", 32'(busy), 32'd0);
        check("drop_rdy", 32'(bus.q_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
